// File: rtl/shift_pipe_if.sv
// rtl/shift_pipe_if.sv - operand/result handshake bundle for shift_pipe
interface shift_pipe_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic [SHW-1:0]   shift;
   logic             right;
   logic             arith;
   logic             rotate;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;

   modport master (
      output in_valid, data_in, shift, right, arith, rotate, out_ready,
      input  in_ready, out_valid, data_out
   );

   modport slave (
      input  in_valid, data_in, shift, right, arith, rotate, out_ready,
      output in_ready, out_valid, data_out
   );
endinterface

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - elastic pipelined barrel shifter; SHIFT_ROTATE_EN adds rotate mode
module shift_pipe #(
   parameter int WIDTH = 32,
   parameter int PIPE  = 2
) (
   input logic         clk,
   input logic         rst_n,
   shift_pipe_if.slave bus
);
   localparam int SHW   = $clog2(WIDTH);
   localparam int BASE  = SHW / PIPE;
   localparam int EXTRA = SHW % PIPE;

   // First shift level handled by stage s; earlier stages absorb the remainder.
   function automatic int lvl_lo(input int s);
      return s * BASE + ((s < EXTRA) ? s : EXTRA);
   endfunction

   function automatic logic [WIDTH-1:0] shift_level(
      input logic [WIDTH-1:0] d,
      input int               n,
      input logic             r,
      input logic             a,
      input logic             rot
   );
      logic [WIDTH-1:0] fill;
      logic [WIDTH-1:0] res;
      if (r) begin
         fill = rot ? d : {WIDTH{a & d[WIDTH-1]}};
         res  = (d >> n) | (fill << (WIDTH - n));
      end else begin
         fill = rot ? d : '0;
         res  = (d << n) | (fill >> (WIDTH - n));
      end
      return res;
   endfunction

   logic [PIPE-1:0]  valid_q, valid_d;
   logic [WIDTH-1:0] data_q  [PIPE];
   logic [WIDTH-1:0] data_d  [PIPE];
   logic [SHW-1:0]   shift_q [PIPE];
   logic [SHW-1:0]   shift_d [PIPE];
   logic [PIPE-1:0]  right_q, right_d;
   logic [PIPE-1:0]  arith_q, arith_d;
`ifdef SHIFT_ROTATE_EN
   logic [PIPE-1:0]  rot_q, rot_d;
`endif
   logic [PIPE:0]    adv;

   always_comb begin
      logic [WIDTH-1:0] d;
      logic [SHW-1:0]   sh;
      logic             v, r, a, rot;
      int               p;
      d   = '0;
      sh  = '0;
      v   = 1'b0;
      r   = 1'b0;
      a   = 1'b0;
      rot = 1'b0;
      p   = 0;

      // adv[s]: stage s register may load this cycle
      adv[PIPE] = bus.out_ready;
      for (int s = PIPE - 1; s >= 0; s--) begin
         adv[s] = !valid_q[s] || adv[s+1];
      end

      valid_d = valid_q;
      data_d  = data_q;
      shift_d = shift_q;
      right_d = right_q;
      arith_d = arith_q;
`ifdef SHIFT_ROTATE_EN
      rot_d   = rot_q;
`endif

      for (int s = 0; s < PIPE; s++) begin
         p = (s > 0) ? s - 1 : 0;
         if (s == 0) begin
            v  = bus.in_valid;
            d  = bus.data_in;
            sh = bus.shift;
            r  = bus.right;
            a  = bus.arith;
         end else begin
            v  = valid_q[p];
            d  = data_q[p];
            sh = shift_q[p];
            r  = right_q[p];
            a  = arith_q[p];
         end
`ifdef SHIFT_ROTATE_EN
         rot = (s == 0) ? bus.rotate : rot_q[p];
`else
         rot = 1'b0;
`endif
         for (int i = 0; i < SHW; i++) begin
            if (i >= lvl_lo(s) && i < lvl_lo(s + 1) && sh[i]) begin
               d = shift_level(d, 1 << i, r, a, rot);
            end
         end
         if (adv[s]) begin
            valid_d[s] = v;
            data_d[s]  = d;
            shift_d[s] = sh;
            right_d[s] = r;
            arith_d[s] = a;
`ifdef SHIFT_ROTATE_EN
            rot_d[s]   = rot;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         right_q <= '0;
         arith_q <= '0;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= '0;
`endif
         for (int s = 0; s < PIPE; s++) begin
            data_q[s]  <= '0;
            shift_q[s] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         shift_q <= shift_d;
         right_q <= right_d;
         arith_q <= arith_d;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = valid_q[PIPE-1];
   assign bus.data_out  = data_q[PIPE-1];

   // Control bits of the final stage have no consumer downstream.
   logic unused_ctl;
`ifdef SHIFT_ROTATE_EN
   assign unused_ctl = ^{shift_q[PIPE-1], right_q[PIPE-1], arith_q[PIPE-1], rot_q[PIPE-1]};
`else
   assign unused_ctl = ^{shift_q[PIPE-1], right_q[PIPE-1], arith_q[PIPE-1], bus.rotate};
`endif
endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed self-checking bench for shift_pipe at 32/2 and 8/3
module tb_shift_pipe;
`ifdef SHIFT_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, right, arith, rotate, out_ready, sel;
   logic [31:0] data_in;
   logic [4:0]  shift_amt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int n_out    = 0;
   int n_stall  = 0;
   int first_acc = -1;
   int first_out = -1;
   int last_out  = -1;
   bit mon_en  = 1'b0;
   bit chk_lat = 1'b0;
   logic [31:0] exp_q[$];
   int          acc_q[$];

   shift_pipe_if #(.WIDTH(32)) a_if ();
   shift_pipe_if #(.WIDTH(8))  b_if ();

   shift_pipe #(.WIDTH(32), .PIPE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   shift_pipe #(.WIDTH(8),  .PIPE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

   assign a_if.in_valid  = in_valid & ~sel;
   assign a_if.data_in   = data_in;
   assign a_if.shift     = shift_amt;
   assign a_if.right     = right;
   assign a_if.arith     = arith;
   assign a_if.rotate    = rotate;
   assign a_if.out_ready = out_ready;
   assign b_if.in_valid  = in_valid & sel;
   assign b_if.data_in   = data_in[7:0];
   assign b_if.shift     = shift_amt[2:0];
   assign b_if.right     = right;
   assign b_if.arith     = arith;
   assign b_if.rotate    = rotate;
   assign b_if.out_ready = out_ready;

   wire        o_in_ready = sel ? b_if.in_ready  : a_if.in_ready;
   wire        o_valid    = sel ? b_if.out_valid : a_if.out_valid;
   wire [31:0] o_data     = sel ? {24'h0, b_if.data_out} : a_if.data_out;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cur_w();
      return sel ? 8 : 32;
   endfunction

   function automatic int cur_p();
      return sel ? 3 : 2;
   endfunction

   function automatic logic [31:0] pat(input int j);
      return 32'hA5C3_0F96 ^ (j * 32'h1111_1111);
   endfunction

   // Bit-by-bit reference: result bit j is taken from source bit j -/+ shift.
   function automatic logic [31:0] ref_model(input logic [31:0] d, input int sh, input logic r,
                                             input logic a, input logic rot, input int w);
      logic [31:0] res;
      int          src;
      res = '0;
      for (int j = 0; j < w; j++) begin
         src = r ? j + sh : j - sh;
         if (rot && ROT_EN) res[j] = d[(src + w) % w];
         else if (src >= 0 && src < w) res[j] = d[src];
         else res[j] = r & a & d[w-1];
      end
      return res;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (o_valid && out_ready) begin
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            chk("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               logic [31:0] e;
               int          ac;
               e  = exp_q.pop_front();
               ac = acc_q.pop_front();
               chk("data", o_data, e);
               if (chk_lat) chk("latency", cyc - ac, cur_p());
            end
         end
         if (in_valid && o_in_ready) begin
            exp_q.push_back(ref_model(data_in, int'(shift_amt) & (cur_w() - 1), right, arith,
                                      rotate, cur_w()));
            acc_q.push_back(cyc);
            if (first_acc < 0) first_acc = cyc;
            n_acc++;
         end
      end
   end

   task automatic send(input logic [31:0] d, input int sh, input logic r, input logic a,
                       input logic rot);
      data_in   = d;
      shift_amt = sh[4:0];
      right     = r;
      arith     = a;
      rotate    = rot;
      in_valid  = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (o_in_ready) begin
            @(posedge clk);
            #1;
            return;
         end
         n_stall++;
         @(posedge clk);
         #1;
      end
      chk("send_timeout", o_in_ready, 1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic run_one(input string tag, input logic [31:0] d, input int sh, input logic r,
                          input logic a, input logic rot, input logic [31:0] want);
      send(d, sh, r, a, rot);
      in_valid = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (o_valid) break;
      end
      chk({tag, "_valid"}, o_valid, 1);
      chk(tag, o_data, want);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, %0d checks done", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int          o0, a0, j, cnt;
      bit          have;
      logic [31:0] held;
      rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; data_in = '0; shift_amt = '0;
      right = 1'b0; arith = 1'b0; rotate = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid_a", a_if.out_valid, 0);
      chk("rst_data_a", a_if.data_out, 0);
      chk("rst_out_valid_b", b_if.out_valid, 0);
      chk("rst_data_b", b_if.data_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_in_ready_a", a_if.in_ready, 1);
      chk("rst_in_ready_b", b_if.in_ready, 1);
      @(posedge clk); #1;
      mon_en = 1'b1;

      for (int dut = 0; dut < 2; dut++) begin
         sel = dut[0];
         // all shift amounts in the four right/arith combinations
         chk_lat = 1'b1;
         o0 = n_out;
         for (int c = 0; c < 4; c++) begin
            for (int sh = 0; sh < cur_w(); sh++) send(32'hAAAA_AAAA, sh, c[1], c[0], 1'b0);
         end
         drain();
         chk("t1_count", n_out - o0, 4 * cur_w());
         chk("t1_empty", exp_q.size(), 0);

         // eight back-to-back ops
         o0 = n_out; n_stall = 0; first_acc = -1; first_out = -1;
         for (int k = 0; k < 8; k++) send(pat(k), k % cur_w(), k[0], k[1], 1'b0);
         drain();
         chk("t3_count", n_out - o0, 8);
         chk("t3_first_latency", first_out - first_acc, cur_p());
         chk("t3_span", last_out - first_out, 7);
         chk("t3_in_ready_held", n_stall, 0);

         // downstream stall for five cycles under continuous input
         chk_lat = 1'b0;
         o0 = n_out; a0 = n_acc; out_ready = 1'b0; j = 0; have = 1'b0; held = '0;
         for (int t = 0; t < 5; t++) begin
            data_in = pat(j); shift_amt = 5'(j % cur_w()); right = j[0]; arith = j[1];
            rotate = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            if (o_in_ready) j++;
            if (o_valid) begin
               if (have) chk("t4_hold", o_data, held);
               else begin have = 1'b1; held = o_data; end
            end
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         @(negedge clk);
         chk("t4_accepts", j, cur_p());
         chk("t4_in_ready", o_in_ready, 0);
         chk("t4_out_valid", o_valid, 1);
         chk("t4_hold_final", o_data, held);
         @(posedge clk); #1;
         out_ready = 1'b1;
         while (j < 8) begin
            send(pat(j), j % cur_w(), j[0], j[1], 1'b0);
            j++;
         end
         drain();
         chk("t4_count", n_out - o0, 8);
         chk("t4_acc", n_acc - a0, 8);
         chk("t4_empty", exp_q.size(), 0);
      end

      chk_lat = 1'b1;
      sel = 1'b1;
      run_one("b_arith_r3", 32'h80, 3, 1, 1, 0, 32'hF0);
      run_one("b_left7", 32'h01, 7, 0, 0, 0, 32'h80);
      run_one("b_logic_r7", 32'h80, 7, 1, 0, 0, 32'h01);

      sel = 1'b0;
      run_one("arith_r4", 32'h8000_0000, 4, 1, 1, 0, 32'hF800_0000);
      run_one("logic_r4", 32'h8000_0000, 4, 1, 0, 0, 32'h0800_0000);
      run_one("left1", 32'hAAAA_AAAA, 1, 0, 0, 0, 32'h5555_5554);
      run_one("left_arith_ignored", 32'h8000_0003, 2, 0, 1, 0, 32'h0000_000C);
      run_one("shift0", 32'h1234_5678, 0, 1, 1, 0, 32'h1234_5678);
      run_one("rot_r1", 32'h8000_0001, 1, 1, 0, 1, ROT_EN ? 32'hC000_0000 : 32'h4000_0000);
      run_one("rot_l4", 32'h1234_5678, 4, 0, 0, 1, ROT_EN ? 32'h2345_6781 : 32'h2345_6780);

      // reset with two ops in flight
      mon_en = 1'b0;
      out_ready = 1'b0;
      send(32'h0F0F_0F0F, 3, 0, 0, 0);
      send(32'hF0F0_F0F0, 5, 1, 1, 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_full_valid", o_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", o_valid, 0);
      chk("t6_rst_data", o_data, 0);
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      cnt = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (o_valid) cnt++;
      end
      chk("t6_no_stale", cnt, 0);
      @(posedge clk); #1;
      mon_en = 1'b1;
      run_one("post_reset", 32'h0000_00F0, 4, 0, 0, 0, 32'h0000_0F00);
      drain();
      chk("final_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
